// File: rtl/fetch_decode_queue.sv
// fetch_decode_queue: IF->ID instruction queue, up to INSTR_COUNT packets pushed/popped per cycle.
// Optional same-cycle empty-queue bypass is enabled by defining FETCH_QUEUE_BYPASS_EN.
module fetch_decode_queue #(
  parameter int unsigned PACKET_SIZE = 65,
  parameter int unsigned INSTR_COUNT = 2,
  parameter int unsigned DEPTH       = 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               flush_i,
  input  logic [INSTR_COUNT-1:0]             valid_i,
  input  logic [INSTR_COUNT*PACKET_SIZE-1:0] data_i,
  output logic                               ready_o,
  output logic [INSTR_COUNT-1:0]             valid_o,
  output logic [INSTR_COUNT*PACKET_SIZE-1:0] data_o,
  input  logic [INSTR_COUNT-1:0]             pop_i,
  output logic [$clog2(DEPTH+1)-1:0]         count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [PACKET_SIZE-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]       head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]       count_q, count_d;

  logic                               bypass;
  logic                               push_ok;
  logic [CNT_W-1:0]                   push_n, pop_n, skip_n, enq_n, deq_n;
  logic [INSTR_COUNT-1:0]             pop_eff;
  logic [INSTR_COUNT-1:0]             wr_en;
  logic [PTR_W-1:0]                   wr_addr [INSTR_COUNT];
  logic [INSTR_COUNT-1:0]             q_valid;
  logic [INSTR_COUNT*PACKET_SIZE-1:0] q_data;

  function automatic logic [CNT_W-1:0] popcnt(input logic [INSTR_COUNT-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < int'(INSTR_COUNT); i++) begin
      c = c + CNT_W'(v[i]);
    end
    return c;
  endfunction

  // Space check uses registered count only, so same-cycle pops never admit a push.
  assign ready_o = (CNT_W'(DEPTH) - count_q) >= CNT_W'(INSTR_COUNT);
  assign count_o = count_q;

  always_comb begin
    logic [PTR_W-1:0] rd_idx;
    rd_idx  = '0;
    q_valid = '0;
    q_data  = '0;
    for (int k = 0; k < int'(INSTR_COUNT); k++) begin
      rd_idx = head_q + PTR_W'(k);
      if (count_q > CNT_W'(k)) begin
        q_valid[k]                             = 1'b1;
        q_data[k*PACKET_SIZE +: PACKET_SIZE]   = mem_q[rd_idx];
      end
    end
  end

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = (count_q == '0) && !flush_i;

  always_comb begin
    valid_o = q_valid;
    data_o  = q_data;
    if (bypass) begin
      valid_o = valid_i;
      for (int k = 0; k < int'(INSTR_COUNT); k++) begin
        data_o[k*PACKET_SIZE +: PACKET_SIZE] =
            valid_i[k] ? data_i[k*PACKET_SIZE +: PACKET_SIZE] : '0;
      end
    end
  end
`else
  assign bypass  = 1'b0;
  assign valid_o = q_valid;
  assign data_o  = q_data;
`endif

  assign pop_eff = pop_i & valid_o;
  assign push_ok = ready_o && !flush_i;

  always_comb begin
    push_n = push_ok ? popcnt(valid_i) : '0;
    pop_n  = popcnt(pop_eff);
    // While bypassing, popped slots come straight from the input and are never stored.
    skip_n = bypass ? pop_n : '0;
    deq_n  = bypass ? '0 : pop_n;
    enq_n  = push_n - skip_n;
    wr_en  = '0;
    for (int k = 0; k < int'(INSTR_COUNT); k++) begin
      wr_en[k]   = push_ok && valid_i[k] && (CNT_W'(k) >= skip_n);
      wr_addr[k] = tail_q + PTR_W'(CNT_W'(k) - skip_n);
    end
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PTR_W'(deq_n);
      tail_d  = tail_q + PTR_W'(enq_n);
      count_d = count_q + enq_n - deq_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < int'(INSTR_COUNT); k++) begin
      if (wr_en[k]) begin
        mem_q[wr_addr[k]] <= data_i[k*PACKET_SIZE +: PACKET_SIZE];
      end
    end
  end

  // A mask is contiguous from slot 0 exactly when mask & (mask + 1) is zero.
  logic [INSTR_COUNT-1:0] valid_inc, pop_inc;
  assign valid_inc = valid_i + INSTR_COUNT'(1);
  assign pop_inc   = pop_i + INSTR_COUNT'(1);

  valid_contig_a: assert property (@(posedge clk) disable iff (!rst_n)
    (valid_i & valid_inc) == '0);

  pop_prefix_a: assert property (@(posedge clk) disable iff (!rst_n)
    (pop_i & pop_inc) == '0);

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Scoreboard bench for fetch_decode_queue: a queue model predicts count/ready/valid/data each cycle.
module tb_fetch_decode_queue;
  localparam int unsigned PS = 65;
  localparam int unsigned IC = 2;
  localparam int unsigned DP = 8;
  localparam int unsigned DW = PS * IC;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush_i;
  logic [1:0]    valid_i;
  logic [DW-1:0] data_i;
  logic          ready_o;
  logic [1:0]    valid_o;
  logic [DW-1:0] data_o;
  logic [1:0]    pop_i;
  logic [3:0]    count_o;

  fetch_decode_queue #(
    .PACKET_SIZE(PS),
    .INSTR_COUNT(IC),
    .DEPTH      (DP)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush_i(flush_i),
    .valid_i(valid_i),
    .data_i (data_i),
    .ready_o(ready_o),
    .valid_o(valid_o),
    .data_o (data_o),
    .pop_i  (pop_i),
    .count_o(count_o)
  );

  always #5 clk = ~clk;

  int            total = 0;
  int            bad = 0;
  logic [PS-1:0] sb[$];
  logic [31:0]   popped[$];
  logic [31:0]   next_pc;
  logic [31:0]   fpc;
  logic [1:0]    pend_v;
  logic [1:0]    s_valid;
  logic [DW-1:0] s_data;
  int            peak_cnt;

  function automatic logic [PS-1:0] mk(input logic [31:0] pc);
    return {pc, pc ^ 32'hA5A5_0F0F, pc[2]};
  endfunction

  task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Sample at negedge, compare to model, then advance model to match the coming posedge.
  task automatic cycle();
    logic          byp;
    logic          exp_rdy;
    logic [1:0]    ev;
    logic [DW-1:0] ed;
    logic [PS-1:0] e;
    int            n;
    @(negedge clk);
    byp = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
    byp = (sb.size() == 0) && !flush_i;
`endif
    exp_rdy = (sb.size() <= int'(DP - IC));
    ev = '0;
    ed = '0;
    for (int k = 0; k < 2; k++) begin
      if (byp) begin
        ev[k] = valid_i[k];
        if (valid_i[k]) ed[k*PS +: PS] = data_i[k*PS +: PS];
      end else if (sb.size() > k) begin
        ev[k] = 1'b1;
        ed[k*PS +: PS] = sb[k];
      end
    end
    check_eq("count", DW'(count_o), DW'(sb.size()));
    check_eq("ready", DW'(ready_o), DW'(exp_rdy));
    check_eq("valid", DW'(valid_o), DW'(ev));
    check_eq("data", data_o, ed);
    s_valid = valid_o;
    s_data  = data_o;
    if (int'(count_o) > peak_cnt) peak_cnt = int'(count_o);
    n = 0;
    for (int k = 0; k < 2; k++) n += int'(valid_i[k]);
    if (flush_i) begin
      sb.delete();
      next_pc += 32'(4 * n);
      pend_v = '0;
    end else begin
      if (exp_rdy && n > 0) begin
        for (int k = 0; k < 2; k++) if (valid_i[k]) sb.push_back(data_i[k*PS +: PS]);
        next_pc += 32'(4 * n);
        pend_v = '0;
      end
      for (int k = 0; k < 2; k++) begin
        if (pop_i[k] && valid_o[k]) popped.push_back(data_o[k*PS+33 +: 32]);
        if (pop_i[k] && ev[k] && sb.size() > 0) e = sb.pop_front();
      end
    end
    @(posedge clk);
    #1;
  endtask

  // IF side holds its group until the model says it was accepted.
  task automatic drive(input logic [1:0] v, input logic [1:0] p, input logic fl);
    if (pend_v == 2'b00) pend_v = v;
    valid_i = pend_v;
    for (int k = 0; k < 2; k++) begin
      data_i[k*PS +: PS] = pend_v[k] ? mk(next_pc + 32'(4 * k)) : '0;
    end
    pop_i   = p;
    flush_i = fl;
    cycle();
  endtask

  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      if (sb.size() > 0 || pend_v != 2'b00) drive(2'b00, 2'b11, 1'b0);
    end
    check_eq("drain_count", DW'(count_o), DW'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] rv;
    logic [1:0] rp;
    rst_n = 1'b0; flush_i = 1'b0; valid_i = '0; pop_i = '0; data_i = '0;
    next_pc = '0; pend_v = '0; peak_cnt = 0;
    #12 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset mid-traffic at occupancy 5
    drive(2'b00, 2'b00, 1'b0);
    drive(2'b11, 2'b00, 1'b0);
    drive(2'b11, 2'b00, 1'b0);
    drive(2'b01, 2'b00, 1'b0);
    check_eq("pre_rst_count", DW'(count_o), DW'(5));
    valid_i = 2'b00; pop_i = 2'b11;
    #1 rst_n = 1'b0;
    #1;
    check_eq("rst_count", DW'(count_o), DW'(0));
    check_eq("rst_valid", DW'(valid_o), DW'(0));
    check_eq("rst_ready", DW'(ready_o), DW'(1));
    check_eq("rst_data", data_o, '0);
    sb.delete(); pend_v = '0; pop_i = '0; data_i = '0;
    #1 rst_n = 1'b1;

    // Fill to full, hold a fifth group, then drain in order
    popped.delete();
    next_pc = 32'h0;
    repeat (4) drive(2'b11, 2'b00, 1'b0);
    check_eq("full_count", DW'(count_o), DW'(8));
    check_eq("full_ready", DW'(ready_o), DW'(0));
    drive(2'b11, 2'b00, 1'b0);
    drive(2'b11, 2'b00, 1'b0);
    check_eq("held_count", DW'(count_o), DW'(8));
    drain();
    for (int i = 0; i < 10; i++) check_eq("fill_order", DW'(popped[i]), DW'(32'(4 * i)));

    // Push 2 / pop 1 steady state across pointer wrap
    popped.delete();
    next_pc = 32'h1000;
    repeat (40) drive(2'b11, 2'b01, 1'b0);
    drain();
    check_eq("wrap_len", DW'(popped.size()), DW'((next_pc - 32'h1000) >> 2));
    for (int i = 0; i < popped.size(); i++) begin
      check_eq("wrap_seq", DW'(popped[i]), DW'(32'h1000 + 32'(4 * i)));
    end

    // Partial group then full group, pop 1 per cycle
    popped.delete();
    peak_cnt = 0;
    next_pc = 32'h100;
    drive(2'b01, 2'b01, 1'b0);
    drive(2'b11, 2'b01, 1'b0);
    drive(2'b00, 2'b01, 1'b0);
    drive(2'b00, 2'b01, 1'b0);
    check_eq("part_len", DW'(popped.size()), DW'(3));
    check_eq("part_0", DW'(popped[0]), DW'(32'h100));
    check_eq("part_1", DW'(popped[1]), DW'(32'h104));
    check_eq("part_2", DW'(popped[2]), DW'(32'h108));
`ifdef FETCH_QUEUE_BYPASS_EN
    check_eq("part_peak", DW'(peak_cnt), DW'(1));
`else
    check_eq("part_peak", DW'(peak_cnt), DW'(2));
`endif

    // Flush at occupancy 6 with simultaneous push and pop
    next_pc = 32'h2000;
    repeat (3) drive(2'b11, 2'b00, 1'b0);
    fpc = next_pc;
    drive(2'b11, 2'b11, 1'b1);
    valid_i = '0; pop_i = '0; flush_i = 1'b0;
    #1;
    check_eq("flush_count", DW'(count_o), DW'(0));
    check_eq("flush_valid", DW'(valid_o), DW'(0));
    popped.delete();
    repeat (3) drive(2'b00, 2'b11, 1'b0);
    check_eq("flush_none", DW'(popped.size()), DW'(0));
    drive(2'b11, 2'b00, 1'b0);
    drain();
    check_eq("flush_next", DW'(popped[0]), DW'(fpc + 32'h8));

    // Empty queue, push 2 / pop 1 in the same cycle
    popped.delete();
    next_pc = 32'h200;
    drive(2'b11, 2'b01, 1'b0);
`ifdef FETCH_QUEUE_BYPASS_EN
    check_eq("byp_valid", DW'(s_valid), DW'(2'b11));
    check_eq("byp_slot0", DW'(s_data[33 +: 32]), DW'(32'h200));
    check_eq("byp_count", DW'(count_o), DW'(1));
    check_eq("byp_head", DW'(data_o[33 +: 32]), DW'(32'h204));
`else
    check_eq("byp_valid", DW'(s_valid), DW'(2'b00));
    check_eq("byp_count", DW'(count_o), DW'(2));
    check_eq("byp_head", DW'(data_o[33 +: 32]), DW'(32'h200));
`endif
    drain();

    // Random legal traffic with occasional flushes
    next_pc = 32'h8000;
    for (int i = 0; i < 300; i++) begin
      rv = 2'($urandom_range(0, 2));
      rp = 2'($urandom_range(0, 2));
      if (rv == 2'b10) rv = 2'b11;
      if (rp == 2'b10) rp = 2'b11;
      drive(rv, rp, ($urandom_range(0, 19) == 0));
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
